// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
//
// Multi-cycle control unit for the MIPS-subset datapath. Each instruction is
// stepped through fetch, decode, execute, memory and write-back states. The
// unit drives the PC/IR write enables, the memory request handshake, the
// register-file and ALU steering, and the next-PC select.
//
// Build option:
//   MC_BNE_EN  - when defined, opcode 0x05 (bne) is accepted and branches on
//                !zero. When undefined, 0x05 is an unsupported opcode.
//
// Ports:
//   clock      in  1  system clock, rising edge
//   rst        in  1  asynchronous reset, active low
//   opcode     in  6  IR[31:26]
//   funct      in  6  IR[5:0] (cannot make an instruction illegal: every
//                     R-type opcode 0x00 is accepted)
//   zero       in  1  combinational ALU zero flag for the current cycle
//   mem_ready  in  1  memory completes the current request this cycle
//   pc_ena     out 1  PC write enable
//   ir_ena     out 1  IR write enable
//   mem_req    out 1  memory access request
//   mem_we     out 1  memory request is a write
//   iord       out 1  memory address source (0 = PC, 1 = ALUOut)
//   reg_we     out 1  register-file write enable
//   reg_dst    out 1  destination register (0 = rt, 1 = rd)
//   mem_to_reg out 1  write-back source (0 = ALUOut, 1 = MDR)
//   alu_src_a  out 1  ALU A operand (0 = PC, 1 = A)
//   alu_src_b  out 2  ALU B operand (00 = B, 01 = 4, 10 = imm, 11 = imm << 2)
//   alu_op     out 2  ALU operation (00 = add, 01 = sub, 10 = funct)
//   pc_src     out 2  next PC (00 = ALU result, 01 = ALUOut, 10 = jump)
//   state      out 4  current state code (debug)
//   illegal    out 1  sticky unsupported-opcode flag
// -----------------------------------------------------------------------------
module mc_control (
    input  logic       clock,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_ena,
    output logic       ir_ena,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_IDLE   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

`ifdef MC_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    // funct never influences control: R-type is accepted for any funct.
    logic unused_funct;
    assign unused_funct = ^funct;

    // -------------------------------------------------------------------------
    // State and registered output flops
    // -------------------------------------------------------------------------
    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;

    // Moore outputs are decoded from the next state and registered, so they
    // change on the clock edge together with state_q and glitch-free.
    logic       fetch_q, fetch_d;       // in FETCH: PC/IR enables follow mem_ready
    logic       branch_q, branch_d;     // in BRANCH: PC enable follows zero
    logic       jump_q, jump_d;         // in JUMP: PC enable unconditional
    logic       mem_req_q, mem_req_d;
    logic       mem_we_q, mem_we_d;
    logic       iord_q, iord_d;
    logic       reg_we_q, reg_we_d;
    logic       reg_dst_q, reg_dst_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic [1:0] pc_src_q, pc_src_d;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        if (BNE_EN && (opcode == OP_BNE)) begin
                            state_d = S_BRANCH;
                        end else begin
                            // Unsupported opcode: flag it and skip to the
                            // next instruction.
                            illegal_d = 1'b1;
                            state_d   = S_FETCH;
                        end
                    end
                endcase
            end
            // Only lw/sw reach MEMADR; the opcode is held by IR.
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_RTWB;
            S_RTWB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_IDLE;   // unused codes 12..14 recover via IDLE
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode of the state being entered
    // -------------------------------------------------------------------------
    always_comb begin
        fetch_d      = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        iord_d       = 1'b0;
        reg_we_d     = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        alu_op_d     = 2'b00;
        pc_src_d     = 2'b00;
        case (state_d)
            S_FETCH: begin
                fetch_d     = 1'b1;
                mem_req_d   = 1'b1;
                alu_src_b_d = 2'b01;        // PC + 4
            end
            S_DECODE: begin
                alu_src_b_d = 2'b11;        // branch target precompute
            end
            S_MEMADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEMRD: begin
                mem_req_d   = 1'b1;
                iord_d      = 1'b1;
            end
            S_MEMWB: begin
                reg_we_d     = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            S_MEMWR: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                iord_d      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            S_RTWB: begin
                reg_we_d    = 1'b1;
                reg_dst_d   = 1'b1;
            end
            S_BRANCH: begin
                branch_d    = 1'b1;
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b01;
                pc_src_d    = 2'b01;
            end
            S_ADDIEX: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_ADDIWB: begin
                reg_we_d    = 1'b1;
            end
            S_JUMP: begin
                jump_d      = 1'b1;
                pc_src_d    = 2'b10;
            end
            default: ;                      // IDLE and unused codes: all 0
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            illegal_q    <= 1'b0;
            fetch_q      <= 1'b0;
            branch_q     <= 1'b0;
            jump_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            iord_q       <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_src_a_q  <= 1'b0;
            alu_src_b_q  <= 2'b00;
            alu_op_q     <= 2'b00;
            pc_src_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            illegal_q    <= illegal_d;
            fetch_q      <= fetch_d;
            branch_q     <= branch_d;
            jump_q       <= jump_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            iord_q       <= iord_d;
            reg_we_q     <= reg_we_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            alu_op_q     <= alu_op_d;
            pc_src_q     <= pc_src_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. PC/IR enables carry same-cycle qualification by mem_ready and
    // zero; everything else comes straight from flops.
    // -------------------------------------------------------------------------
    logic branch_take;
    // bne inverts the sense of zero; the opcode is still held by IR here.
    assign branch_take = (BNE_EN && (opcode == OP_BNE)) ? ~zero : zero;

    assign pc_ena     = (fetch_q & mem_ready) | (branch_q & branch_take) | jump_q;
    assign ir_ena     = fetch_q & mem_ready;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign iord       = iord_q;
    assign reg_we     = reg_we_q;
    assign reg_dst    = reg_dst_q;
    assign mem_to_reg = mem_to_reg_q;
    assign alu_src_a  = alu_src_a_q;
    assign alu_src_b  = alu_src_b_q;
    assign alu_op     = alu_op_q;
    assign pc_src     = pc_src_q;
    assign state      = state_q;
    assign illegal    = illegal_q;

endmodule
